wb_commit_queue: RTL

//  Parametrised write-back stage with a DEPTH-entry in-order commit queue between MEM and the register file.
//  - Accepts completed instructions from MEM over a valid/ready handshake.
//  - Retires at most one per cycle, only when the shared RF write port grants it.
//  - Raises a one-cycle flush when an excepting instruction reaches the head.
//  - Serves NUM_FWD parallel forwarding lookups to ID against all buffered results.

---
 rtl/wb_commit_queue.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/wb_commit_queue.sv
// Write-back stage: DEPTH-entry in-order commit queue between MEM and the register file.
// Retires one entry per granted cycle, flushes on an excepting head, and forwards buffered results to ID.
module wb_commit_queue #(
  parameter int DEPTH   = 4,
  parameter int NUM_FWD = 2,
  parameter int DATA_W  = 32,
  parameter int WE_W    = 4
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      flush_in,
  input  logic                      ms_valid,
  output logic                      ws_allowin,
  input  logic [DATA_W-1:0]         ms_pc,
  input  logic [WE_W-1:0]           ms_gr_we,
  input  logic [4:0]                ms_dest,
  input  logic [DATA_W-1:0]         ms_result,
  input  logic                      ms_exc,
  input  logic                      rf_grant,
  output logic [WE_W-1:0]           rf_we,
  output logic [4:0]                rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  output logic                      send_flush,
  output logic [DATA_W-1:0]         flush_pc,
  input  logic [NUM_FWD*5-1:0]      fwd_raddr,
  output logic [NUM_FWD-1:0]        fwd_hit,
  output logic [NUM_FWD*WE_W-1:0]   fwd_we,
  output logic [NUM_FWD*DATA_W-1:0] fwd_data,
  output logic [DATA_W-1:0]         debug_wb_pc,
  output logic [WE_W-1:0]           debug_wb_rf_wen,
  output logic [4:0]                debug_wb_rf_wnum,
  output logic [DATA_W-1:0]         debug_wb_rf_wdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0]  ent_valid;
  logic [DEPTH-1:0]  ent_exc;
  logic [DATA_W-1:0] ent_pc     [DEPTH];
  logic [WE_W-1:0]   ent_we     [DEPTH];
  logic [4:0]        ent_dest   [DEPTH];
  logic [DATA_W-1:0] ent_result [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic head_valid;
  logic head_exc;
  logic head_ok;
  logic retire;
  logic flush_exc;
  logic clear;
  logic push;

  assign head_valid = ent_valid[head];
  assign head_exc   = ent_exc[head];
  assign head_ok    = head_valid && !head_exc && !flush_in;
  assign retire     = head_ok && rf_grant;
  assign flush_exc  = head_valid && head_exc && !flush_in;
  assign clear      = flush_in || flush_exc;

  // Handshake: a transfer happens on a rising edge where ms_valid && ws_allowin.
  // ws_allowin depends only on occupancy and flush_in, never on ms_valid, and a
  // full queue refuses even if the head retires in the same cycle.
  assign ws_allowin = (count != CNT_W'(DEPTH)) && !flush_in;
  assign push       = ms_valid && ws_allowin && !flush_exc;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ent_valid <= '0;
      ent_exc   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_pc[i]     <= '0;
        ent_we[i]     <= '0;
        ent_dest[i]   <= '0;
        ent_result[i] <= '0;
      end
    end else if (clear) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ent_valid <= '0;
    end else begin
      if (retire) begin
        ent_valid[head] <= 1'b0;
        head            <= head + PTR_W'(1);
      end
      // tail never equals head here while retiring: that would need a full queue, which refuses pushes
      if (push) begin
        ent_valid[tail]  <= 1'b1;
        ent_exc[tail]    <= ms_exc;
        ent_pc[tail]     <= ms_pc;
        ent_we[tail]     <= ms_gr_we;
        ent_dest[tail]   <= ms_dest;
        ent_result[tail] <= ms_result;
        tail             <= tail + PTR_W'(1);
      end
      case ({push, retire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    rf_we             = '0;
    rf_waddr          = '0;
    rf_wdata          = '0;
    send_flush        = flush_exc;
    flush_pc          = '0;
    debug_wb_pc       = '0;
    debug_wb_rf_wen   = '0;
    debug_wb_rf_wnum  = '0;
    debug_wb_rf_wdata = '0;
    if (head_ok) begin
      rf_waddr = ent_dest[head];
      rf_wdata = ent_result[head];
    end
    if (retire) begin
      rf_we             = ent_we[head];
      debug_wb_pc       = ent_pc[head];
      debug_wb_rf_wen   = ent_we[head];
      debug_wb_rf_wnum  = ent_dest[head];
      debug_wb_rf_wdata = ent_result[head];
    end
    if (flush_exc) begin
      flush_pc = ent_pc[head];
    end
  end

  // Walk oldest to youngest so the last match (closest to tail) wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    logic [4:0]       ra;
    idx      = '0;
    ra       = '0;
    fwd_hit  = '0;
    fwd_we   = '0;
    fwd_data = '0;
    for (int k = 0; k < NUM_FWD; k++) begin
      ra = fwd_raddr[5*k +: 5];
      for (int i = 0; i < DEPTH; i++) begin
        idx = head + PTR_W'(i);
        if (ent_valid[idx] && !ent_exc[idx] && (|ent_we[idx]) &&
            (ent_dest[idx] == ra) && (ra != 5'd0)) begin
          fwd_hit[k]                 = 1'b1;
          fwd_we[k*WE_W +: WE_W]     = ent_we[idx];
          fwd_data[k*DATA_W +: DATA_W] = ent_result[idx];
        end
      end
    end
  end

endmodule
